// File: rtl/logic_seq_unit.sv
// Byte-serial bitwise logic unit: accepts an operand pair and opcode, evaluates one SLICE per cycle.
// Optional zero flag output enabled by defining LOGIC_SEQ_ZFLAG_EN.
module logic_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
`ifdef LOGIC_SEQ_ZFLAG_EN
  , output logic           out_zero
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_zero;

  logic [LW-1:0]    w_lsb;
  logic [SLICE-1:0] w_slice;

  function automatic logic [SLICE-1:0] f_eval(input logic [2:0] op,
                                              input logic [SLICE-1:0] a,
                                              input logic [SLICE-1:0] b);
    logic [SLICE-1:0] res;
    case (op)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = a ^ b;
      3'd3:    res = ~(a | b);
      3'd4:    res = ~a;
      3'd5:    res = ~(a & b);
      3'd6:    res = ~(a ^ b);
      3'd7:    res = a;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_lsb   = LW'(r_cnt) * LW'(SLICE);
  assign w_slice = f_eval(r_op, r_a[w_lsb +: SLICE], r_b[w_lsb +: SLICE]);

  // Handshake FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'd0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_op       <= in_op;
            r_cnt      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[w_lsb +: SLICE] <= w_slice;
          r_zero <= r_zero & (w_slice == '0);
          // Counter holds at N-1 on the last slice instead of wrapping.
          if (r_cnt == CW'(N - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign busy       = r_busy;
`ifdef LOGIC_SEQ_ZFLAG_EN
  assign out_zero   = r_zero;
`else
  logic w_zero_unused;
  assign w_zero_unused = r_zero;
`endif

endmodule

// File: tb/tb_logic_seq_unit.sv
// Randomized self-checking bench for logic_seq_unit against a whole-word behavioural model.
module tb_logic_seq_unit;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;
`ifdef LOGIC_SEQ_ZFLAG_EN
  logic        out_zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic_seq_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
`ifdef LOGIC_SEQ_ZFLAG_EN
    , .out_zero(out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~a;
      3'd5: return ~(a & b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    in_op    = 3'($urandom_range(0, 7));
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Drives one request with out_ready high; returns at the first cycle out_valid is seen.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit tmo);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    @(posedge clk); #1;
    scramble();
    lat = 0; tmo = 1'b0;
    while (out_valid !== 1'b1) begin
      if (lat >= 20) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
      scramble();
    end
    res = out_result;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #2;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef LOGIC_SEQ_ZFLAG_EN
    n_tests++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero got=%b exp=1", out_zero); end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] as  [5] = '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0, 32'h0000FFFF, 32'h12345678};
    logic [31:0] bs  [5] = '{32'hFF00FF00, 32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h12345678};
    logic [31:0] exps[5] = '{32'hF000F000, 32'hEDCBA987, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF};
    logic [31:0] res; int lat; bit tmo;
    for (int i = 0; i < 5; i++) begin
      do_txn(ops[i], as[i], bs[i], res, lat, tmo);
      n_tests++; if (tmo) begin n_fail++; $display("FAIL dir%0d_timeout no out_valid within 20 cycles", i); end
      n_tests++; if (res !== exps[i]) begin n_fail++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, exps[i]); end
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
      @(posedge clk); #1;
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_handshake in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp; logic [2:0] op; int lat; bit tmo;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if (i % 8 == 0) a = 32'h0;
      exp = model(op, a, b);
      do_txn(op, a, b, res, lat, tmo);
      n_tests++; if (tmo || res !== exp || lat != 4) begin
        n_fail++; $display("FAIL rand%0d op=%0d got=%h exp=%h lat=%0d tmo=%0d", i, op, res, exp, lat, tmo); end
`ifdef LOGIC_SEQ_ZFLAG_EN
      n_tests++; if (out_zero !== (exp == 32'h0)) begin
        n_fail++; $display("FAIL rand%0d_zero got=%b exp=%b", i, out_zero, (exp == 32'h0)); end
`endif
      @(posedge clk); #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_ready got=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0; int bad = 0;
    in_valid = 1'b1; in_op = 3'd1; in_a = 32'h0F0F0F0F; in_b = 32'h00FF00FF; out_ready = 1'b1;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_run_flags bad_cycles=%0d exp=0", bad); end
    n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=4", cyc); end
    n_tests++; if (out_result !== 32'h0FFF0FFF) begin n_fail++; $display("FAIL b2b_result got=%h exp=0FFF0FFF", out_result); end
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp; logic [2:0] op; int cyc = 0; int bad = 0;
    op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; exp = model(op, a, b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    while (out_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL bp_latency got=%0d exp=4", cyc); end
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      scramble();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0 result=%h exp=%h", bad, out_result, exp); end
    n_tests++; if (out_valid !== 1'b1 || out_result !== exp) begin
      n_fail++; $display("FAIL bp_still_valid out_valid=%b result=%h exp 1/%h", out_valid, out_result, exp); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res; int lat; bit tmo; int seen = 0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 32'hDEADBEEF; in_b = 32'h0; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outputs in_ready=%b out_valid=%b busy=%b result=%h exp 1/0/0/0",
                         in_ready, out_valid, busy, out_result); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
    do_txn(3'd5, 32'hFFFFFFFF, 32'h0000FFFF, res, lat, tmo);
    n_tests++; if (tmo || res !== 32'hFFFF0000) begin n_fail++; $display("FAIL midrst_nand got=%h exp=FFFF0000 tmo=%0d", res, tmo); end
    @(posedge clk); #1;
  endtask

`ifdef LOGIC_SEQ_ZFLAG_EN
  task automatic test_zflag();
    logic [31:0] res; int lat; bit tmo;
    do_txn(3'd0, 32'hAAAAAAAA, 32'h55555555, res, lat, tmo);
    n_tests++; if (res !== 32'h0 || out_zero !== 1'b1) begin
      n_fail++; $display("FAIL zflag_and got=%h/%b exp=00000000/1", res, out_zero); end
    @(posedge clk); #1;
    do_txn(3'd1, 32'hAAAAAAAA, 32'h55555555, res, lat, tmo);
    n_tests++; if (res !== 32'hFFFFFFFF || out_zero !== 1'b0) begin
      n_fail++; $display("FAIL zflag_or got=%h/%b exp=FFFFFFFF/0", res, out_zero); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_run();
`ifdef LOGIC_SEQ_ZFLAG_EN
    test_zflag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
